label_overlay: RTL and testbench
================================

LABEL_OVERLAY -- requirements
Module: label_overlay

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning the number of pix_en stages by which video is delayed to align with glyph fetch (range 1..4).
REQ-002 SHALL have parameter FG_COLOR, default 16'hFFFF, meaning the RGB565 colour of set glyph pixels.
REQ-003 SHALL have parameter BG_COLOR, default 16'h0000, meaning the RGB565 colour of clear glyph pixels (used only with LABEL_OVERLAY_BOX_EN).
REQ-004 Port CK, input, 1 bit: the single system clock, rising edge.
REQ-005 Port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port pix_en, input, 1 bit: pixel strobe; all state advances only on CK edges with pix_en=1.
REQ-007 Ports de_in, hs_in and vs_in, inputs, 1 bit each: display enable and syncs from the timing generator.
REQ-008 Port rgb_in, input, 16 bits: spectrogram pixel in RGB565.
REQ-009 Port glyph_row, input, 6 bits: glyph scanline from the character ROM; bit 5 is the leftmost pixel.
REQ-010 Port glyph_load, input, 1 bit: glyph_row is valid and starts a new 6-pixel cell at this pix_en.
REQ-011 Ports de_out, hs_out and vs_out, outputs, 1 bit each: the delayed de/hs/vs.
REQ-012 Port rgb_out, output, 16 bits: the mixed pixel.
REQ-013 Port overrun, output, 1 bit: sticky error flag.

Function
REQ-014 SHALL delay de_in, hs_in, vs_in and rgb_in by exactly LAT pix_en strobes; CK cycles without pix_en SHALL NOT advance the delay.
REQ-015 On pix_en with glyph_load=1, the block SHALL load a 6-bit shifter with glyph_row, set cell_cnt=5 and set cell_act=1.
REQ-016 On pix_en with glyph_load=0 and cell_act=1, the block SHALL shift the shifter left by one and decrement cell_cnt; when cell_cnt=0, it SHALL clear cell_act instead.
REQ-017 The current glyph bit SHALL be shifter[5], valid only while cell_act=1.
REQ-018 rgb_out SHALL be registered and updated on pix_en as follows:
- FG_COLOR if delayed de=1, cell_act=1 and the glyph bit is 1;
- otherwise the delayed rgb.
REQ-019 When delayed de=0, rgb_out SHALL be 16'h0000 regardless of glyph state.
REQ-020 If glyph_load=1 while cell_act=1 and cell_cnt≠0, the new row SHALL win, the remaining bits SHALL be discarded, and overrun SHALL set.
REQ-021 glyph_load on the same pix_en as cell_cnt=0 is back-to-back (cells are contiguous) and SHALL NOT set overrun.
REQ-022 A falling edge of delayed de (1→0) SHALL clear cell_act and the shifter on that pix_en; an in-flight glyph_load on the same strobe is dropped.
REQ-023 Output latency SHALL be one CK edge (the edge on which pix_en=1) from the shifter state to rgb_out, with de_out/hs_out/vs_out registered in the same stage so that all outputs are aligned.

Reset
REQ-024 RST_N=0 SHALL asynchronously clear all delay stages, shifter, cell_cnt, cell_act and overrun.
REQ-025 During reset, de_out=0, hs_out=0, vs_out=0, rgb_out=16'h0000 and overrun=0.
REQ-026 Reset asserted mid-cell SHALL abandon the cell; after release, output SHALL resume on the next glyph_load with no residual pixels.
REQ-027 overrun SHALL clear only on reset.

Configuration
REQ-028 Macro LABEL_OVERLAY_BOX_EN defined: while cell_act=1 and delayed de=1, clear glyph bits SHALL output BG_COLOR, giving an opaque label box.
REQ-029 Macro LABEL_OVERLAY_BOX_EN undefined: clear glyph bits SHALL pass the delayed rgb (transparent), and BG_COLOR SHALL be unused.

Structure
REQ-030 Package label_pkg SHALL hold: the RGB565 typedef, CELL_W=6, GLYPH_MSB=5, default FG/BG colours and the LAT range limits.
REQ-031 Sub-module pix_delay (a parameterised LAT-stage, pix_en-gated register chain for {de,hs,vs,rgb}) SHALL be instantiated once.

Verification
REQ-032 LAT=2, pix_en every 2nd CK, glyph_load with 6'b101101, rgb_in=16'h07E0, de=1 -> rgb_out over 6 strobes is FFFF,07E0,FFFF,FFFF,07E0,FFFF, then 07E0.
REQ-033 Four back-to-back loads (0x3F,0x00,0x21,0x1E), each exactly 6 strobes apart -> 24 contiguous pixels match the bits and overrun stays 0.
REQ-034 Load 6'b111111, then a second load after 3 strobes -> second row output from that strobe and overrun=1 until RST_N=0.
REQ-035 de_in drops to 0 mid-cell -> rgb_out=0000 from that delayed strobe, and no glyph pixels reappear when de returns without a new load.
REQ-036 RST_N pulsed low for 1 CK mid-cell, asynchronous to CK -> all outputs 0 immediately; the first post-reset load renders cleanly.
REQ-037 With LABEL_OVERLAY_BOX_EN, row 6'b100000 over rgb_in=16'h001F -> FFFF followed by 5×0000, then 001F.

Source files
------------

// File: rtl/label_pkg.sv
// Shared types and constants for the label overlay: RGB565 pixel type, glyph
// cell geometry, default colours and the supported video delay range.
package label_pkg;

  typedef logic [15:0] rgb565_t;

  localparam int CELL_W    = 6;
  localparam int GLYPH_MSB = 5;

  localparam rgb565_t DEF_FG = 16'hFFFF;
  localparam rgb565_t DEF_BG = 16'h0000;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // One pixel of the video stream together with its timing flags.
  typedef struct packed {
    logic    de;
    logic    hs;
    logic    vs;
    rgb565_t rgb;
  } vid_t;

endpackage

// File: rtl/label_overlay_if.sv
// Video pixel bus: display enable, syncs and RGB565 colour for one pixel.
interface label_overlay_if;
  import label_pkg::*;

  // Strobe semantics: a pixel is transferred on every CK edge where the owning
  // block's pix_en is 1; there is no back-pressure, the sink must accept it.
  logic    de;
  logic    hs;
  logic    vs;
  rgb565_t rgb;

  modport master (output de, hs, vs, rgb);
  modport slave  (input  de, hs, vs, rgb);

endinterface

// File: rtl/label_overlay_pix_delay.sv
// pix_delay: LAT-stage register chain for {de,hs,vs,rgb} that only advances
// on pix_en, so idle CK cycles leave the alignment untouched.
module pix_delay
  import label_pkg::*;
#(
  parameter int LAT = 2
)
(
  input  logic            ck,
  input  logic            rst_n,
  input  logic            pix_en,
  label_overlay_if.slave  src,
  label_overlay_if.master dst
);

  // Out-of-range depths saturate to the supported range.
  localparam int DEPTH = (LAT < LAT_MIN) ? LAT_MIN :
                         (LAT > LAT_MAX) ? LAT_MAX : LAT;

  vid_t [DEPTH-1:0] stage_q;
  vid_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (pix_en) begin
      stage_d[0] = '{de: src.de, hs: src.hs, vs: src.vs, rgb: src.rgb};
      for (int i = DEPTH - 1; i > 0; i--) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dst.de  = stage_q[DEPTH-1].de;
  assign dst.hs  = stage_q[DEPTH-1].hs;
  assign dst.vs  = stage_q[DEPTH-1].vs;
  assign dst.rgb = stage_q[DEPTH-1].rgb;

endmodule

// File: rtl/label_overlay.sv
// label_overlay: mixes 6-pixel glyph cells from a character ROM over delayed
// video. Define LABEL_OVERLAY_BOX_EN to paint clear glyph bits with BG_COLOR.
module label_overlay
  import label_pkg::*;
#(
  parameter int      LAT      = 2,
  parameter rgb565_t FG_COLOR = DEF_FG,
  parameter rgb565_t BG_COLOR = DEF_BG
)
(
  input  logic              CK,
  input  logic              RST_N,
  input  logic              pix_en,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  rgb565_t           rgb_in,
  input  logic [CELL_W-1:0] glyph_row,
  input  logic              glyph_load,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out,
  output rgb565_t           rgb_out,
  output logic              overrun
);

  localparam logic [2:0] CNT_LAST = 3'(CELL_W - 1);

  label_overlay_if vid_in ();
  label_overlay_if vid_dly ();

  assign vid_in.de  = de_in;
  assign vid_in.hs  = hs_in;
  assign vid_in.vs  = vs_in;
  assign vid_in.rgb = rgb_in;

  pix_delay #(.LAT(LAT)) u_pix_delay (
    .ck     (CK),
    .rst_n  (RST_N),
    .pix_en (pix_en),
    .src    (vid_in),
    .dst    (vid_dly)
  );

  logic [CELL_W-1:0] shift_q, shift_d;
  logic [2:0]        cnt_q,   cnt_d;
  logic              act_q,   act_d;
  logic              ovr_q,   ovr_d;
  vid_t              out_q,   out_d;

  logic    glyph_bit;
  logic    de_fall;
  rgb565_t mix_px;

  assign glyph_bit = shift_q[GLYPH_MSB];
  // out_q.de holds the delayed de of the previous strobe.
  assign de_fall   = out_q.de & ~vid_dly.de;

`ifdef LABEL_OVERLAY_BOX_EN
  always_comb begin
    if (!vid_dly.de)             mix_px = '0;
    else if (act_q && glyph_bit) mix_px = FG_COLOR;
    else if (act_q)              mix_px = BG_COLOR;
    else                         mix_px = vid_dly.rgb;
  end
`else
  logic unused_bg;
  assign unused_bg = ^BG_COLOR;

  always_comb begin
    if (!vid_dly.de)             mix_px = '0;
    else if (act_q && glyph_bit) mix_px = FG_COLOR;
    else                         mix_px = vid_dly.rgb;
  end
`endif

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    ovr_d   = ovr_q;
    out_d   = out_q;
    if (pix_en) begin
      out_d = '{de: vid_dly.de, hs: vid_dly.hs, vs: vid_dly.vs, rgb: mix_px};
      // End of the active line kills the cell; a load on this strobe is lost.
      if (de_fall) begin
        shift_d = '0;
        cnt_d   = '0;
        act_d   = 1'b0;
      end else if (glyph_load) begin
        shift_d = glyph_row;
        cnt_d   = CNT_LAST;
        act_d   = 1'b1;
        if (act_q && (cnt_q != '0)) begin
          ovr_d = 1'b1;
        end
      end else if (act_q) begin
        if (cnt_q == '0) begin
          act_d = 1'b0;
        end else begin
          shift_d = {shift_q[CELL_W-2:0], 1'b0};
          cnt_d   = cnt_q - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      shift_q <= '0;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      ovr_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      ovr_q   <= ovr_d;
      out_q   <= out_d;
    end
  end

  assign de_out  = out_q.de;
  assign hs_out  = out_q.hs;
  assign vs_out  = out_q.vs;
  assign rgb_out = out_q.rgb;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_label_overlay.sv
// Bench for label_overlay (LAT=2): table of strobes with hand-computed outputs,
// plus directed sequences for async reset, de drop and the opaque box build.
module tb_label_overlay;
  import label_pkg::*;

  localparam int LAT = 2;
  localparam logic [15:0] GRN = 16'h07E0;
  localparam logic [15:0] WHT = 16'hFFFF;
`ifdef LABEL_OVERLAY_BOX_EN
  localparam logic [15:0] CLR = 16'h0000;
`else
  localparam logic [15:0] CLR = GRN;
`endif

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
    logic        ld;
    logic [5:0]  row;
    logic        e_de;
    logic        e_hs;
    logic        e_vs;
    logic [15:0] e_rgb;
    logic        e_ovr;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       glyph_load = 1'b0;
  logic [5:0] glyph_row = '0;
  logic       overrun;

  label_overlay_if vin ();
  label_overlay_if vout ();

  always #5 ck = ~ck;

  label_overlay #(.LAT(LAT)) dut (
    .CK         (ck),
    .RST_N      (rst_n),
    .pix_en     (pix_en),
    .de_in      (vin.de),
    .hs_in      (vin.hs),
    .vs_in      (vin.vs),
    .rgb_in     (vin.rgb),
    .glyph_row  (glyph_row),
    .glyph_load (glyph_load),
    .de_out     (vout.de),
    .hs_out     (vout.hs),
    .vs_out     (vout.vs),
    .rgb_out    (vout.rgb),
    .overrun    (overrun)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, " de_out"},  {15'd0, vout.de}, {15'd0, v.e_de});
    check({tag, " hs_out"},  {15'd0, vout.hs}, {15'd0, v.e_hs});
    check({tag, " vs_out"},  {15'd0, vout.vs}, {15'd0, v.e_vs});
    check({tag, " rgb_out"}, vout.rgb, v.e_rgb);
    check({tag, " overrun"}, {15'd0, overrun}, {15'd0, v.e_ovr});
  endtask

  // ---------------- driver ----------------
  // gap idle CK cycles (pix_en=0) precede each strobe; outputs sampled #1 after it.
  task automatic strobe(input vec_t v, input int gap);
    repeat (gap) @(posedge ck);
    @(negedge ck);
    vin.de = v.de; vin.hs = v.hs; vin.vs = v.vs; vin.rgb = v.rgb;
    glyph_load = v.ld; glyph_row = v.row; pix_en = 1'b1;
    @(posedge ck);
    #1;
    pix_en = 1'b0;
    glyph_load = 1'b0;
  endtask

  function automatic vec_t mk(input logic de, input logic [15:0] rgb, input logic ld,
                              input logic [5:0] row, input logic e_de,
                              input logic [15:0] e_rgb, input logic e_ovr);
    vec_t v;
    v = '{de: de, hs: 1'b0, vs: 1'b0, rgb: rgb, ld: ld, row: row,
          e_de: e_de, e_hs: 1'b0, e_vs: 1'b0, e_rgb: e_rgb, e_ovr: e_ovr};
    return v;
  endfunction

  task automatic run(input string tag, input vec_t v, input int gap);
    strobe(v, gap);
    check_out(tag, v);
  endtask

  // ---------------- stimulus ----------------
  vec_t       tbl[48];
  logic [5:0] rows[4];
  logic [15:0] r32[6];
  logic [15:0] r34[6];
  logic [15:0] e_d[7];
  logic        de_d[7];

  initial begin
    vin.de = 1'b0; vin.hs = 1'b0; vin.vs = 1'b0; vin.rgb = '0;

    // Default row: de=1 green video, no glyph, output is the delayed green.
    for (int i = 0; i < 48; i++) tbl[i] = mk(1'b1, GRN, 1'b0, 6'd0, 1'b1, GRN, 1'b0);
    // Pipeline fill and hs/vs alignment: inputs appear LAT strobes later.
    tbl[0].hs = 1'b1; tbl[1].vs = 1'b1;
    tbl[0].e_de = 1'b0; tbl[0].e_rgb = '0;
    tbl[1].e_de = 1'b0; tbl[1].e_rgb = '0;
    tbl[2].e_hs = 1'b1; tbl[3].e_vs = 1'b1;
    // Single row 101101 loaded at 3, pixels on strobes 4..9.
    tbl[3].ld = 1'b1; tbl[3].row = 6'b101101;
    r32 = '{WHT, CLR, WHT, WHT, CLR, WHT};
    for (int b = 0; b < 6; b++) tbl[4+b].e_rgb = r32[b];
    // Four back-to-back cells loaded at 11,17,23,29.
    rows = '{6'h3F, 6'h00, 6'h21, 6'h1E};
    for (int c = 0; c < 4; c++) begin
      tbl[11+6*c].ld  = 1'b1;
      tbl[11+6*c].row = rows[c];
      for (int b = 0; b < 6; b++) tbl[12+6*c+b].e_rgb = rows[c][5-b] ? WHT : CLR;
    end
    // Overrun: 111111 at 37, 010101 at 40 cuts it short.
    tbl[37].ld = 1'b1; tbl[37].row = 6'b111111;
    for (int b = 38; b <= 40; b++) tbl[b].e_rgb = WHT;
    tbl[40].ld = 1'b1; tbl[40].row = 6'b010101;
    r34 = '{CLR, WHT, CLR, WHT, CLR, WHT};
    for (int b = 0; b < 6; b++) tbl[41+b].e_rgb = r34[b];
    for (int b = 40; b < 48; b++) tbl[b].e_ovr = 1'b1;

    // Reset state while RST_N is held low.
    #17;
    check("reset de_out",  {15'd0, vout.de}, 16'd0);
    check("reset hs_out",  {15'd0, vout.hs}, 16'd0);
    check("reset vs_out",  {15'd0, vout.vs}, 16'd0);
    check("reset rgb_out", vout.rgb, 16'd0);
    check("reset overrun", {15'd0, overrun}, 16'd0);
    @(negedge ck);
    rst_n = 1'b1;

    for (int i = 0; i < 48; i++) run($sformatf("tbl[%0d]", i), tbl[i], 1);

    // Async reset mid-cell (overrun is still 1 here).
    run("mid load", mk(1'b1, GRN, 1'b1, 6'b111111, 1'b1, GRN, 1'b1), 1);
    run("mid bit5", mk(1'b1, GRN, 1'b0, 6'd0, 1'b1, WHT, 1'b1), 1);
    @(negedge ck);
    #2;
    rst_n = 1'b0;
    #1;
    check("async de_out",  {15'd0, vout.de}, 16'd0);
    check("async rgb_out", vout.rgb, 16'd0);
    check("async overrun", {15'd0, overrun}, 16'd0);
    #9;
    rst_n = 1'b1;
    run("post p0", mk(1'b1, GRN, 1'b0, 6'd0, 1'b0, 16'h0000, 1'b0), 1);
    run("post p1", mk(1'b1, GRN, 1'b0, 6'd0, 1'b0, 16'h0000, 1'b0), 1);
    run("post p2", mk(1'b1, GRN, 1'b0, 6'd0, 1'b1, GRN, 1'b0), 1);
    run("post p3", mk(1'b1, GRN, 1'b1, 6'b100001, 1'b1, GRN, 1'b0), 1);
    run("post p4", mk(1'b1, GRN, 1'b0, 6'd0, 1'b1, WHT, 1'b0), 1);
    for (int b = 5; b <= 8; b++)
      run($sformatf("post p%0d", b), mk(1'b1, GRN, 1'b0, 6'd0, 1'b1, CLR, 1'b0), 1);
    run("post p9", mk(1'b1, GRN, 1'b0, 6'd0, 1'b1, WHT, 1'b0), 1);
    run("post p10", mk(1'b1, GRN, 1'b0, 6'd0, 1'b1, GRN, 1'b0), 1);

    // de drops mid-cell with long idle gaps; the cell must not resume.
    run("dedrop q0", mk(1'b1, GRN, 1'b1, 6'b111111, 1'b1, GRN, 1'b0), 3);
    de_d = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    e_d  = '{WHT, WHT, 16'h0000, 16'h0000, GRN, GRN, GRN};
    for (int q = 0; q < 7; q++)
      run($sformatf("dedrop q%0d", q + 1),
          mk(de_d[q], GRN, 1'b0, 6'd0, (e_d[q] != 16'h0000), e_d[q], 1'b0), 3);

`ifdef LABEL_OVERLAY_BOX_EN
    run("box r0", mk(1'b1, 16'h001F, 1'b0, 6'd0, 1'b1, GRN, 1'b0), 1);
    run("box r1", mk(1'b1, 16'h001F, 1'b0, 6'd0, 1'b1, GRN, 1'b0), 1);
    run("box r2", mk(1'b1, 16'h001F, 1'b1, 6'b100000, 1'b1, 16'h001F, 1'b0), 1);
    run("box r3", mk(1'b1, 16'h001F, 1'b0, 6'd0, 1'b1, WHT, 1'b0), 1);
    for (int b = 4; b <= 8; b++)
      run($sformatf("box r%0d", b), mk(1'b1, 16'h001F, 1'b0, 6'd0, 1'b1, 16'h0000, 1'b0), 1);
    run("box r9", mk(1'b1, 16'h001F, 1'b0, 6'd0, 1'b1, 16'h001F, 1'b0), 1);
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
